// File: rtl/serial_sequencer.sv
// Parallel-to-serial frame sequencer with back-to-back loads and frame looping.
// Define SERIAL_SEQUENCER_PARITY_EN to append an even parity bit to every frame.
module serial_sequencer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  load,
    input  logic                  msb_first,
    input  logic                  loop,
    output logic                  ready,
    output logic                  ds,
    output logic                  valid,
    output logic                  frame,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout
);

    localparam int CW = $clog2(DATA_WIDTH + 1);
`ifdef SERIAL_SEQUENCER_PARITY_EN
    localparam int N = DATA_WIDTH + 1;
`else
    localparam int N = DATA_WIDTH;
`endif
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]    state;
    logic [CW-1:0] idx;
    logic [CW-1:0] nxt_idx;
    logic          order;
    logic          last;

    // Shifting instead of indexing keeps the parity slot (k == DATA_WIDTH) in range.
    function automatic logic frame_bit(input logic [DATA_WIDTH-1:0] word,
                                       input logic                  msb,
                                       input logic [CW-1:0]         k);
        logic [DATA_WIDTH-1:0] sh;
        logic                  b;
        sh = msb ? (word << k) : (word >> k);
        b  = msb ? sh[DATA_WIDTH-1] : sh[0];
`ifdef SERIAL_SEQUENCER_PARITY_EN
        if (k == CW'(DATA_WIDTH))
            b = ^word;
`endif
        return b;
    endfunction

    assign last    = (state == SHIFT) && (idx == LAST);
    assign nxt_idx = idx + 1'b1;
    // ready reacts to the live loop input so a non-looping last bit can accept the next word.
    assign ready   = (state == IDLE) || (last && !loop);

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state <= IDLE;
            idx   <= '0;
            order <= 1'b0;
            ds    <= 1'b0;
            valid <= 1'b0;
            frame <= 1'b0;
            done  <= 1'b0;
            dout  <= '0;
        end else if (load && ready) begin
            state <= SHIFT;
            idx   <= '0;
            order <= msb_first;
            dout  <= din;
            ds    <= frame_bit(din, msb_first, '0);
            valid <= 1'b1;
            frame <= 1'b1;
            done  <= 1'b0;
        end else if (state == SHIFT) begin
            if (last) begin
                if (loop) begin
                    idx   <= '0;
                    ds    <= frame_bit(dout, order, '0);
                    frame <= 1'b1;
                    done  <= 1'b0;
                end else begin
                    state <= IDLE;
                    idx   <= '0;
                    ds    <= 1'b0;
                    valid <= 1'b0;
                    frame <= 1'b0;
                    done  <= 1'b0;
                end
            end else begin
                idx   <= nxt_idx;
                ds    <= frame_bit(dout, order, nxt_idx);
                frame <= 1'b0;
                done  <= (nxt_idx == LAST);
            end
        end
    end

endmodule

// File: tb/tb_serial_sequencer.sv
// Randomized and directed bench for serial_sequencer against a frame-level reference model.
// Honours SERIAL_SEQUENCER_PARITY_EN the same way as the design.
module tb_serial_sequencer;

    localparam int DW = 8;
`ifdef SERIAL_SEQUENCER_PARITY_EN
    localparam int N = DW + 1;
`else
    localparam int N = DW;
`endif

    logic          clk = 1'b0;
    logic          clr, load, msb_first, loop;
    logic [DW-1:0] din;
    logic          ready, ds, valid, frame, done;
    logic [DW-1:0] dout;

    int errors = 0;
    int checks = 0;

    // Reference model: a frame is "busy at position pos of word m_word".
    bit       m_known = 1'b0;
    bit       m_busy  = 1'b0;
    int       m_pos   = 0;
    int       m_word  = 0;
    bit       m_msb   = 1'b0;

    serial_sequencer #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .clr(clr), .din(din), .load(load), .msb_first(msb_first),
        .loop(loop), .ready(ready), .ds(ds), .valid(valid), .frame(frame),
        .done(done), .dout(dout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit model_bit(input int word, input bit msb, input int k);
        if (k == DW)
            return bit'($countones(word) % 2);
        return msb ? bit'((word >> (DW - 1 - k)) & 1) : bit'((word >> k) & 1);
    endfunction

    // One clock cycle: apply inputs, compare against the model, advance the model.
    task automatic step(input bit c, input bit l, input int d, input bit m, input bit lp);
        bit exp_ready;
        @(negedge clk);
        clr = c; load = l; din = DW'(d); msb_first = m; loop = lp;
        #1;
        exp_ready = !m_busy || (m_pos == N - 1 && !lp);
        if (m_known) begin
            check("valid", valid, m_busy);
            check("ds",    ds,    m_busy ? model_bit(m_word, m_msb, m_pos) : 1'b0);
            check("frame", frame, m_busy && m_pos == 0);
            check("done",  done,  m_busy && m_pos == N - 1);
            check("dout",  dout,  m_word);
            check("ready", ready, exp_ready);
        end
        if (c) begin
            m_known = 1'b1; m_busy = 1'b0; m_pos = 0; m_word = 0;
        end else if (l && exp_ready) begin
            m_busy = 1'b1; m_pos = 0; m_word = d & ((1 << DW) - 1); m_msb = m;
        end else if (m_busy) begin
            if (m_pos == N - 1) begin
                m_pos = 0;
                if (!lp) m_busy = 1'b0;
            end else begin
                m_pos++;
            end
        end
    endtask

    initial begin
        clr = 1'b1; load = 1'b0; din = '0; msb_first = 1'b0; loop = 1'b0;

        // Reset held with a pending load of all ones.
        step(1, 1, 'hFF, 1, 0);
        step(1, 1, 'hFF, 1, 0);
        step(0, 0, 0, 0, 0);
        check("reset_dout", dout, 0);
        check("reset_ready", ready, 1'b1);

        // Single MSB-first frame, then idle.
        step(0, 1, 'h0E, 1, 0);
        for (int i = 0; i < N + 2; i++) step(0, 0, 'h55, 0, 0);
        check("dout_0e", dout, 'h0E);

        // Single LSB-first frame.
        step(0, 1, 'h0E, 0, 0);
        for (int i = 0; i < N + 2; i++) step(0, 0, 'hAA, 1, 0);

        // Load held high: back-to-back words, second captured at the last bit.
        for (int i = 0; i < N; i++) step(0, 1, 'h0E, 1, 0);
        for (int i = 0; i < N; i++) step(0, 1, 'h0F, 1, 0);
        step(0, 0, 'h0F, 1, 0);
        check("dout_0f", dout, 'h0F);
        for (int i = 0; i < N + 1; i++) step(0, 0, 0, 0, 0);

        // Looping frame with changing din, then loop released.
        step(0, 1, 'hA5, 1, 1);
        for (int i = 0; i < 3 * N; i++) step(0, 1, $urandom, $urandom_range(0, 1), 1);
        for (int i = 0; i < N + 2; i++) step(0, 0, 0, 0, 0);
        check("dout_a5", dout, 'hA5);

        // Abort at bit 3, then a clean frame.
        step(0, 1, 'h3C, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        check("abort_done", done, 1'b0);
        step(0, 1, 'hC3, 1, 0);
        for (int i = 0; i < N + 1; i++) step(0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 63) == 0, $urandom_range(0, 1), $urandom,
                 $urandom_range(0, 1), $urandom_range(0, 3) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
